// File: rtl/imem_loader_pkg.sv
// Package: imem_loader_pkg
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the image-format constants (header length, bytes per instruction word).
// The CSUM state only exists when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_HDR0  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_DATA  = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CSUM  = 3'd3,
`endif
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Module: imem_word_packer
// Shifts accepted bytes (MSB first) into a 32-bit accumulator and flags a
// one-cycle word_valid in the cycle after the 4th byte of each word.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (clears index/valid)
//   byte_vld    - a byte is transferred this cycle
//   byte_in     - the byte
//   word        - assembled big-endian word (valid while word_valid=1)
//   word_valid  - one-cycle strobe, cycle after the 4th byte
//   idx         - position of the next byte within the word (0..3)
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             byte_vld,
  input  logic [7:0]       byte_in,
  output logic [31:0]      word,
  output logic             word_valid,
  output logic [IDX_W-1:0] idx
);

  logic [31:0]      acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    vld_d = 1'b0;
    if (byte_vld) begin
      acc_d = {acc_q[23:0], byte_in};
      // Index is exactly wide enough to wrap 3 -> 0 on its own.
      idx_d = idx_q + 1'b1;
      vld_d = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      vld_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      vld_q <= vld_d;
    end
  end

  // Accumulator is pure data; it is fully overwritten before it is used.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  // The accumulator cannot change before the write cycle ends: the next
  // byte lands at the earliest on the edge that closes that cycle.
  assign word       = acc_q;
  assign word_valid = vld_q;
  assign idx        = idx_q;

endmodule

// File: rtl/imem_loader.sv
// Module: imem_loader
// Writer side of the instruction-memory interface. Takes a byte stream
// (2-byte big-endian word count N, then 4*N payload bytes), writes big-endian
// words to sequential word addresses from 0, and holds the core in reset
// until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte
// over header+payload; mismatch ends in ERROR instead of DONE.
// Ports:
//   Clk, Reset            - clock, synchronous active-low reset
//   InByte/InValid/InReady- byte stream (transfer = InValid & InReady)
//   Reload                - pulse in DONE/ERROR restarts the load
//   ImWrEn/ImWrAddr/ImWrData - instruction-memory write port
//   CoreResetN            - 0 holds the core in reset
//   Done, Error           - load status
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        InByte,
  input  logic              InValid,
  output logic              InReady,
  input  logic              Reload,
  output logic              ImWrEn,
  output logic [ADDR_W-1:0] ImWrAddr,
  output logic [31:0]       ImWrData,
  output logic              CoreResetN,
  output logic              Done,
  output logic              Error
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_PAYLOAD_END = ST_CSUM;
`else
  localparam state_e ST_PAYLOAD_END = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [7:0]        hdr_hi_q, hdr_hi_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              xfer;
  logic [15:0]       hdr_n;
  logic              pk_byte_vld;
  logic [31:0]       pk_word;
  logic              pk_word_valid;
  logic [IDX_W-1:0]  pk_idx;

  assign xfer        = InValid & InReady;
  assign hdr_n       = {hdr_hi_q, InByte};
  assign pk_byte_vld = xfer && (state_q == ST_DATA);

  imem_word_packer u_packer (
    .clk        (Clk),
    .rst_n      (Reset),
    .byte_vld   (pk_byte_vld),
    .byte_in    (InByte),
    .word       (pk_word),
    .word_valid (pk_word_valid),
    .idx        (pk_idx)
  );

  always_comb begin
    state_d  = state_q;
    hdr_hi_d = hdr_hi_q;
    n_d      = n_q;
    words_d  = words_q;
    addr_d   = addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    InReady    = 1'b0;
    Done       = 1'b0;
    Error      = 1'b0;
    CoreResetN = 1'b0;

    // The address advances after each word write is presented.
    if (pk_word_valid) addr_d = addr_q + 1'b1;

    case (state_q)
      ST_HDR0: begin
        InReady = 1'b1;
        if (xfer) begin
          hdr_hi_d = InByte;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d   = InByte;
`endif
          state_d  = ST_HDR1;
        end
      end
      ST_HDR1: begin
        InReady = 1'b1;
        if (xfer) begin
          n_d     = hdr_n;
          words_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ InByte;
`endif
          if ({1'b0, hdr_n} > MAX_N) state_d = ST_ERROR;
          else if (hdr_n == 16'd0)   state_d = ST_PAYLOAD_END;
          else                       state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        InReady = 1'b1;
        if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ InByte;
`endif
          if (pk_idx == IDX_W'(BYTES_PER_WORD - 1)) begin
            words_d = words_q + 16'd1;
            // Leave DATA on the same edge the last word is latched, so the
            // final write coincides with the first DONE cycle.
            if (words_q + 16'd1 == n_q) state_d = ST_PAYLOAD_END;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        InReady = 1'b1;
        if (xfer) state_d = (InByte == csum_q) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE: begin
        Done       = 1'b1;
        CoreResetN = 1'b1;
        if (Reload) begin
          state_d = ST_HDR0;
          addr_d  = '0;
        end
      end
      ST_ERROR: begin
        Error = 1'b1;
        if (Reload) begin
          state_d = ST_HDR0;
          addr_d  = '0;
        end
      end
      default: state_d = ST_HDR0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_HDR0;
      n_q     <= '0;
      words_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      words_q <= words_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge Clk) begin
    hdr_hi_q <= hdr_hi_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_q   <= csum_d;
`endif
  end

  assign ImWrEn   = pk_word_valid;
  assign ImWrAddr = addr_q;
  assign ImWrData = pk_word;

endmodule
